uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/uart_tx_framed.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter.
//   - tx_state_e : FSM state encoding (StParity exists only when UART_TX_PARITY_EN is defined)
//   - PAR_*      : parity-mode constants for the PARITY_MODE parameter
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts CLKS_PER_BIT cycles while enabled and strobes bit_end on the last cycle of each bit.
// Ports:
//   clk     - clock (rising edge)
//   rst     - synchronous active-high reset
//   restart - force the count back to zero (start of a new frame)
//   en      - count enable (high while a frame is on the line)
//   bit_end - high during the final cycle of the current bit period
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = en && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      // Wrap to zero at the terminal value so the next bit starts cleanly.
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with a one-entry holding register for back-to-back frames.
// Frame: start (0), DATA_BITS data LSB first, optional parity, STOP_BITS stop (1).
// Optional feature macro: UART_TX_PARITY_EN -- when defined, PARITY_MODE (1 even, 2 odd)
// adds a parity bit; when undefined no parity logic exists and PARITY_MODE is ignored.
// Ports:
//   clk       - clock (rising edge)
//   rst       - synchronous active-high reset; aborts any frame and drops a held byte
//   tx_dv     - byte-valid strobe; accepted when tx_dv && tx_ready
//   tx_byte   - data to send
//   tx_ready  - holding register empty
//   tx_active - high across a frame or an unbroken run of frames
//   tx_done   - one-cycle pulse after the last stop-bit cycle of each frame
//   tx_serial - registered serial line, idle high
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_dv,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_ready,
  output logic                 tx_active,
  output logic                 tx_done,
  output logic                 tx_serial
);

  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit ParityOn = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
  localparam bit ParityOdd = (PARITY_MODE == PAR_ODD);
  logic par_q, par_d;
`endif

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 serial_q, serial_d;
  logic                 active_q;
  logic                 done_q, done_d;

  logic                 bit_end;
  logic                 accept;
  logic                 load;
  logic [DATA_BITS-1:0] load_byte;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(load),
    .en     (state_q != StIdle),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_byte   = tx_byte;
    accept      = tx_dv && !hold_full_q;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        load     = accept;
      end
      StStart: begin
        if (bit_end) begin
          state_d  = StData;
          serial_d = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == DataLast) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            if (ParityOn) begin
              state_d  = StParity;
              serial_d = par_q;
            end else begin
              state_d  = StStop;
              serial_d = 1'b1;
            end
`else
            state_d  = StStop;
            serial_d = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d  = StStop;
          serial_d = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (bit_idx_q == StopLast) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            if (hold_full_q) begin
              // Drain the held byte straight into the next frame, no idle gap.
              load        = 1'b1;
              load_byte   = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              load = 1'b1;
            end else begin
              state_d  = StIdle;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        serial_d = 1'b1;
      end
    endcase

    if (load) begin
      state_d   = StStart;
      serial_d  = 1'b0;
      shift_d   = load_byte;
      bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
      par_d     = (^load_byte) ^ ParityOdd;
`endif
    end else if (accept && (state_q != StIdle)) begin
      // Frame in flight: park the byte until the current stop bit ends.
      hold_d      = tx_byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      serial_q    <= serial_d;
      active_q    <= (state_d != StIdle);
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign tx_serial = serial_q;
  assign tx_ready  = !hold_full_q;
  assign tx_active = active_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed self-checking bench for uart_tx_framed.
// Instances: 0 = 8N1, 1 = 5 data / 2 stop, 2 = PARITY_MODE 1, 3 = PARITY_MODE 2 (all 4 clk/bit).
// Sample index k counts clock edges after the transfer edge; k = 0 is sampled #1 after it.
module tb_uart_tx_framed;

  localparam int Cpb = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv   [4];
  logic [7:0] byt  [4];
  logic       rdy  [4];
  logic       act  [4];
  logic       don  [4];
  logic       ser  [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_framed #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .tx_dv(dv[0]), .tx_byte(byt[0]), .tx_ready(rdy[0]),
    .tx_active(act[0]), .tx_done(don[0]), .tx_serial(ser[0])
  );
  uart_tx_framed #(.CLKS_PER_BIT(Cpb), .DATA_BITS(5), .STOP_BITS(2), .PARITY_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .tx_dv(dv[1]), .tx_byte(byt[1][4:0]), .tx_ready(rdy[1]),
    .tx_active(act[1]), .tx_done(don[1]), .tx_serial(ser[1])
  );
  uart_tx_framed #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .tx_dv(dv[2]), .tx_byte(byt[2]), .tx_ready(rdy[2]),
    .tx_active(act[2]), .tx_done(don[2]), .tx_serial(ser[2])
  );
  uart_tx_framed #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(2)) dut_d (
    .clk(clk), .rst(rst), .tx_dv(dv[3]), .tx_byte(byt[3]), .tx_ready(rdy[3]),
    .tx_active(act[3]), .tx_done(don[3]), .tx_serial(ser[3])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line pattern: frame bit b (bit 0 first on the line) held for cpb samples, idle high after.
  function automatic logic [127:0] expand(input logic [31:0] bits, input int nbits, input int cpb);
    logic [127:0] r;
    r = '1;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) r[b*cpb+c] = bits[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] span(input int lo, input int hi);
    logic [127:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic send(input int sel, input logic [7:0] b);
    dv[sel]  = 1'b1;
    byt[sel] = b;
    @(posedge clk);
    #1;
    dv[sel] = 1'b0;
  endtask

  // Record n samples; optionally strobe tx_dv at k1/k2 and rst at krst (-1 = never).
  task automatic capture(input int sel, input int n, input int k1, input logic [7:0] b1,
                         input int k2, input logic [7:0] b2, input int krst,
                         output logic [127:0] o_ser, output logic [127:0] o_act,
                         output logic [127:0] o_don, output logic [127:0] o_rdy);
    o_ser = '0;
    o_act = '0;
    o_don = '0;
    o_rdy = '0;
    for (int k = 0; k < n; k++) begin
      o_ser[k] = ser[sel];
      o_act[k] = act[sel];
      o_don[k] = don[sel];
      o_rdy[k] = rdy[sel];
      dv[sel] = 1'b0;
      if (k == k1) begin
        dv[sel]  = 1'b1;
        byt[sel] = b1;
      end else if (k == k2) begin
        dv[sel]  = 1'b1;
        byt[sel] = b2;
      end
      rst = (k == krst);
      @(posedge clk);
      #1;
    end
    dv[sel] = 1'b0;
    rst     = 1'b0;
  endtask

  logic [127:0] s, a, d, r, m;

  initial begin
    for (int i = 0; i < 4; i++) begin
      dv[i]  = 1'b0;
      byt[i] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial", 128'(ser[0]), 128'd1);
    check("rst_active", 128'(act[0]), 128'd0);
    check("rst_done",   128'(don[0]), 128'd0);
    check("rst_ready",  128'(rdy[0]), 128'd1);
    check("rst_serial_b", 128'(ser[1]), 128'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 0x55, 8N1: 0,1,0,1,0,1,0,1,0,1 then idle; done at k=40.
    send(0, 8'h55);
    capture(0, 48, -1, 8'h00, -1, 8'h00, -1, s, a, d, r);
    m = span(0, 47);
    check("x55_line",   s & m, expand(32'b1010101010, 10, Cpb) & m);
    check("x55_active", a, span(0, 39));
    check("x55_done",   d, span(40, 40));
    check("x55_ready",  r, m);

    // 0xA0 then 0x3C held (accepted at edge 6), 0xFF at edge 11 dropped; zero idle gap.
    send(0, 8'hA0);
    capture(0, 90, 5, 8'h3C, 10, 8'hFF, -1, s, a, d, r);
    m = span(0, 89);
    check("b2b_line",   s & m, expand(32'b1001111000_1101000000, 20, Cpb) & m);
    check("b2b_active", a, span(0, 79));
    check("b2b_done",   d, span(40, 40) | span(80, 80));
    check("b2b_ready",  r, m & ~span(6, 39));

    // Reset during data bit 3 (k=16..19) with 0x3C held: line high at k=18, nothing afterwards.
    send(0, 8'hA0);
    capture(0, 90, 5, 8'h3C, -1, 8'h00, 17, s, a, d, r);
    m = span(0, 89);
    check("rst_mid_line",   s & m, m & ~span(0, 17));
    check("rst_mid_active", a, span(0, 17));
    check("rst_mid_done",   d, 128'd0);
    check("rst_mid_ready",  r, m & ~span(6, 17));

    // 5 data bits, 2 stop: 0x13 -> 0,1,1,0,0,1,1,1; 32-cycle frame.
    send(1, 8'h13);
    capture(1, 40, -1, 8'h00, -1, 8'h00, -1, s, a, d, r);
    m = span(0, 39);
    check("d5s2_line",   s & m, expand(32'b11100110, 8, Cpb) & m);
    check("d5s2_active", a, span(0, 31));
    check("d5s2_done",   d, span(32, 32));

    // 0x07: even parity 1, odd parity 0; parity bit only exists in the parity build.
    send(2, 8'h07);
    capture(2, 52, -1, 8'h00, -1, 8'h00, -1, s, a, d, r);
    m = span(0, 51);
`ifdef UART_TX_PARITY_EN
    check("even_line",   s & m, expand(32'b11000001110, 11, Cpb) & m);
    check("even_active", a, span(0, 43));
    check("even_done",   d, span(44, 44));
`else
    check("even_line",   s & m, expand(32'b1000001110, 10, Cpb) & m);
    check("even_active", a, span(0, 39));
    check("even_done",   d, span(40, 40));
`endif

    send(3, 8'h07);
    capture(3, 52, -1, 8'h00, -1, 8'h00, -1, s, a, d, r);
    m = span(0, 51);
`ifdef UART_TX_PARITY_EN
    check("odd_line",   s & m, expand(32'b10000001110, 11, Cpb) & m);
    check("odd_active", a, span(0, 43));
    check("odd_done",   d, span(44, 44));
`else
    check("odd_line",   s & m, expand(32'b1000001110, 10, Cpb) & m);
    check("odd_active", a, span(0, 39));
    check("odd_done",   d, span(40, 40));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
